// File: rtl/lisp_defs.sv
// Shared types and constants for the Lisp machine heap memory.
package lisp_defs;

  localparam logic [15:0] LISP_NIL = 16'h0000;

  typedef logic [11:0] addr_t;
  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    StIdle,
    StWrCdr,
    StWrCar
  } cons_state_e;

endpackage

// File: rtl/lisp_memory.sv
// Word-addressed heap: registered read port plus a bump-pointer cons-cell allocator.
// Optional heap-full detection is enabled by defining LISP_MEM_FULL_CHECK_EN.
module lisp_memory
  import lisp_defs::*;
#(
  parameter int unsigned HeapStart  = 1,
  parameter int unsigned MemorySize = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [11:0] addr_in,
  output logic        data_ready,
  output logic [15:0] data_out,
  input  logic        cons_en,
  input  logic [15:0] cons_car,
  input  logic [15:0] cons_cdr,
  output logic        cons_done,
  output logic [15:0] cons_ptr
);

  word_t memory [0:MemorySize-1];

  // One spare bit lets the free pointer step past the last word so heap-full is detectable.
  cons_state_e  state_q, state_d;
  logic  [12:0] free_q, free_d;
  word_t        car_q, car_d;
  word_t        cdr_q, cdr_d;
  logic         full_q, full_d;
  logic         done_q, done_d;
  word_t        ptr_q, ptr_d;
  word_t        rdata_q;
  logic         ready_q;

  logic  mem_we;
  addr_t mem_waddr;
  word_t mem_wdata;

  function automatic addr_t wrap(input logic [13:0] a);
    return addr_t'(a % MemorySize);
  endfunction

  always_comb begin
    state_d   = state_q;
    free_d    = free_q;
    car_d     = car_q;
    cdr_d     = cdr_q;
    full_d    = full_q;
    done_d    = 1'b0;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    mem_waddr = wrap({1'b0, free_q});
    mem_wdata = cdr_q;
    unique case (state_q)
      StIdle: begin
        if (cons_en) begin
          car_d   = cons_car;
          cdr_d   = cons_cdr;
`ifdef LISP_MEM_FULL_CHECK_EN
          full_d  = (({1'b0, free_q} + 14'd1) > 14'(MemorySize - 1));
`else
          full_d  = 1'b0;
`endif
          state_d = StWrCdr;
        end
      end
      StWrCdr: begin
        mem_we  = !full_q;
        state_d = StWrCar;
      end
      StWrCar: begin
        mem_we    = !full_q;
        mem_waddr = wrap({1'b0, free_q} + 14'd1);
        mem_wdata = car_q;
        done_d    = 1'b1;
        if (full_q) begin
          ptr_d = LISP_NIL;
        end else begin
          ptr_d = {4'h0, wrap({1'b0, free_q})};
`ifdef LISP_MEM_FULL_CHECK_EN
          free_d = free_q + 13'd2;
`else
          free_d = {1'b0, wrap({1'b0, free_q} + 14'd2)};
`endif
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      free_q  <= 13'(HeapStart);
      car_q   <= '0;
      cdr_q   <= '0;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      free_q  <= free_d;
      car_q   <= car_d;
      cdr_q   <= cdr_d;
      full_q  <= full_d;
      done_q  <= done_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else if (req) begin
      ready_q <= 1'b1;
      rdata_q <= memory[addr_in];
    end else begin
      ready_q <= 1'b0;
    end
  end

  // No reset on the array: contents survive reset, including half-written cells.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      memory[mem_waddr] <= mem_wdata;
    end
  end

  assign data_ready = ready_q;
  assign data_out   = rdata_q;
  assign cons_done  = done_q;
  assign cons_ptr   = ptr_q;

endmodule

// File: tb/tb_lisp_memory.sv
// Directed bench for lisp_memory: default heap instance plus a near-full heap instance.
module tb_lisp_memory;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req        [2];
  logic [11:0] addr_in    [2];
  logic        data_ready [2];
  logic [15:0] data_out   [2];
  logic        cons_en    [2];
  logic [15:0] cons_car   [2];
  logic [15:0] cons_cdr   [2];
  logic        cons_done  [2];
  logic [15:0] cons_ptr   [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lisp_memory u_dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req[0]),
    .addr_in    (addr_in[0]),
    .data_ready (data_ready[0]),
    .data_out   (data_out[0]),
    .cons_en    (cons_en[0]),
    .cons_car   (cons_car[0]),
    .cons_cdr   (cons_cdr[0]),
    .cons_done  (cons_done[0]),
    .cons_ptr   (cons_ptr[0])
  );

  lisp_memory #(
    .HeapStart (4094)
  ) u_dut_top (
    .clk        (clk),
    .rst        (rst),
    .req        (req[1]),
    .addr_in    (addr_in[1]),
    .data_ready (data_ready[1]),
    .data_out   (data_out[1]),
    .cons_en    (cons_en[1]),
    .cons_car   (cons_car[1]),
    .cons_cdr   (cons_cdr[1]),
    .cons_done  (cons_done[1]),
    .cons_ptr   (cons_ptr[1])
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Full allocation from an idle FSM; inputs change on falling edges.
  task automatic do_cons(input int d, input logic [15:0] car, input logic [15:0] cdr,
                         input logic [15:0] exp_ptr);
    @(negedge clk);
    cons_en[d]  = 1'b1;
    cons_car[d] = car;
    cons_cdr[d] = cdr;
    @(negedge clk);
    cons_en[d] = 1'b0;
    check("done_after_e0", 16'(cons_done[d]), 16'h0);
    @(negedge clk);
    check("done_after_e1", 16'(cons_done[d]), 16'h0);
    @(negedge clk);
    check("done_at_e2", 16'(cons_done[d]), 16'h1);
    check("cons_ptr", cons_ptr[d], exp_ptr);
    @(negedge clk);
    check("done_drop_e3", 16'(cons_done[d]), 16'h0);
    check("cons_ptr_hold", cons_ptr[d], exp_ptr);
  endtask

  // Leaves req asserted so consecutive calls form back-to-back reads.
  task automatic do_read(input int d, input logic [11:0] a, input logic [15:0] exp);
    req[d]     = 1'b1;
    addr_in[d] = a;
    @(negedge clk);
    check("data_ready", 16'(data_ready[d]), 16'h1);
    check("data_out", data_out[d], exp);
  endtask

  initial begin
    logic [15:0] rd_exp [6];
    int          n_done;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; addr_in[d] = '0; cons_en[d] = 1'b0;
      cons_car[d] = '0; cons_cdr[d] = '0;
    end
    rd_exp = '{16'hBEEF, 16'hDEAD, 16'h5678, 16'h1234, 16'hEF01, 16'hABCD};

    #12;
    check("rst_data_ready", 16'(data_ready[0]), 16'h0);
    check("rst_data_out", data_out[0], 16'h0);
    check("rst_cons_done", 16'(cons_done[0]), 16'h0);
    check("rst_cons_ptr", cons_ptr[0], 16'h0);
    @(negedge clk);
    rst = 1'b0;

    do_cons(0, 16'hDEAD, 16'hBEEF, 16'h0001);
    do_cons(0, 16'h1234, 16'h5678, 16'h0003);
    do_cons(0, 16'hABCD, 16'hEF01, 16'h0005);

    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      do_read(0, 12'(i + 1), rd_exp[i]);
    end
    req[0] = 1'b0;
    @(negedge clk);
    check("ready_drop", 16'(data_ready[0]), 16'h0);
    check("data_out_hold", data_out[0], 16'hABCD);

    // Second cons_en pulse lands while the FSM is in WR_CDR.
    cons_en[0] = 1'b1; cons_car[0] = 16'h1111; cons_cdr[0] = 16'h2222;
    @(negedge clk);
    cons_car[0] = 16'h3333; cons_cdr[0] = 16'h4444;
    @(negedge clk);
    cons_en[0] = 1'b0;
    n_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cons_done[0]) n_done++;
    end
    check("ignored_done_count", 16'(n_done), 16'h1);
    check("ignored_cons_ptr", cons_ptr[0], 16'h0007);
    do_read(0, 12'h007, 16'h2222);
    do_read(0, 12'h008, 16'h1111);
    req[0] = 1'b0;
    do_cons(0, 16'h5555, 16'h6666, 16'h0009);

    // Reset while in WR_CAR.
    @(negedge clk);
    cons_en[0] = 1'b1;
    @(negedge clk);
    cons_en[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_cons_done", 16'(cons_done[0]), 16'h0);
    check("midrst_cons_ptr", cons_ptr[0], 16'h0);
    check("midrst_data_out", data_out[0], 16'h0);
    @(negedge clk);
    rst = 1'b0;
    do_cons(0, 16'h7777, 16'h8888, 16'h0001);

    // Near-full heap instance.
    do_cons(1, 16'h0AAA, 16'h0BBB, 16'h0FFE);
    @(negedge clk);
    do_read(1, 12'hFFE, 16'h0BBB);
    do_read(1, 12'hFFF, 16'h0AAA);
`ifdef LISP_MEM_FULL_CHECK_EN
    begin
      logic [15:0] base0, base1;
      do_read(1, 12'h000, data_out[1]);
      base0 = data_out[1];
      do_read(1, 12'h001, data_out[1]);
      base1 = data_out[1];
      req[1] = 1'b0;
      do_cons(1, 16'hC0DE, 16'h0000, 16'h0000);
      @(negedge clk);
      do_read(1, 12'h000, base0);
      do_read(1, 12'h001, base1);
      do_read(1, 12'hFFE, 16'h0BBB);
      req[1] = 1'b0;
      do_cons(1, 16'hC0DE, 16'h0000, 16'h0000);
    end
`else
    req[1] = 1'b0;
    do_cons(1, 16'hC0DE, 16'h0000, 16'h0000);
    @(negedge clk);
    do_read(1, 12'h000, 16'h0000);
    do_read(1, 12'h001, 16'hC0DE);
    req[1] = 1'b0;
    do_cons(1, 16'h1357, 16'h2468, 16'h0002);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
